// File: rtl/cpu_trace_capture.sv
// Circular trace buffer for pc/instruction/address with PC-match trigger and oldest-first readout.
// Optional build macro CPU_TRACE_DEDUP_EN suppresses back-to-back duplicate samples.
module cpu_trace_capture #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int POST   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_en,
    input  logic [DATA_W-1:0]            pc,
    input  logic [DATA_W-1:0]            instruction,
    input  logic [DATA_W-1:0]            address,
    input  logic                         arm,
    input  logic [DATA_W-1:0]            trig_pc,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH)-1:0]     trig_idx,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [DATA_W-1:0]            rd_pc,
    output logic [DATA_W-1:0]            rd_instr,
    output logic [DATA_W-1:0]            rd_addr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = 3 * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRIG, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, trig_idx_q;
    logic [CW-1:0]   count_q, post_left_q, rd_left_q;
    logic [EW-1:0]   mem [DEPTH];

    logic [EW-1:0]   smp;
    logic            dup, store, hit, finish;
    logic [AW-1:0]   wr_inc;
    logic [CW-1:0]   cnt_inc, tidx_full;

    assign smp     = {pc, instruction, address};
    assign hit     = (pc == trig_pc);
    assign store   = sample_en && !arm && !dup && (state_q == S_ARMED || state_q == S_TRIG);
    assign wr_inc  = wr_ptr_q + AW'(1);
    assign cnt_inc = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
    assign tidx_full = cnt_inc - CW'(1) - CW'(POST);
    assign finish  = store && ((state_q == S_ARMED && hit && POST == 0) ||
                               (state_q == S_TRIG && post_left_q == CW'(1)));

`ifdef CPU_TRACE_DEDUP_EN
    logic          last_vld_q;
    logic [EW-1:0] last_q;

    assign dup = last_vld_q && (last_q == smp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        last_vld_q <= 1'b0;
        else if (arm)   last_vld_q <= 1'b0;
        else if (store) last_vld_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (store) last_q <= smp;
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: if (store && hit) state_d = (POST == 0) ? S_DONE : S_TRIG;
                S_TRIG:  if (finish)       state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q == S_ARMED) || (state_q == S_TRIG);
        done     = (state_q == S_DONE);
        rd_valid = (state_q == S_DONE) && (rd_left_q != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_left_q <= '0;
            rd_ptr_q    <= '0;
            rd_left_q   <= '0;
            trig_idx_q  <= '0;
        end else if (arm) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_left_q <= CW'(POST);
            rd_ptr_q    <= '0;
            rd_left_q   <= '0;
            trig_idx_q  <= '0;
        end else begin
            if (store) begin
                wr_ptr_q <= wr_inc;
                count_q  <= cnt_inc;
                if (state_q == S_TRIG) post_left_q <= post_left_q - CW'(1);
            end
            // Oldest entry sits count positions behind the post-write pointer.
            if (finish) begin
                trig_idx_q <= tidx_full[AW-1:0];
                rd_ptr_q   <= wr_inc - cnt_inc[AW-1:0];
                rd_left_q  <= cnt_inc;
            end else if (rd_valid && rd_ready) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_left_q <= rd_left_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr_q] <= smp;
    end

    assign count    = count_q;
    assign trig_idx = trig_idx_q;
    assign {rd_pc, rd_instr, rd_addr} = mem[rd_ptr_q];

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture (DEPTH=8, POST=2) plus a POST=0 instance.
module tb_cpu_trace_capture;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_en = 1'b0;
    logic [DW-1:0] pc = '0, instruction = '0, address = '0, trig_pc = '0;
    logic          arm = 1'b0;
    logic          rd_ready = 1'b0;

    logic          busy, done, rd_valid;
    logic [3:0]    count;
    logic [2:0]    trig_idx;
    logic [DW-1:0] rd_pc, rd_instr, rd_addr;

    logic          busy0, done0, rd_valid0;
    logic [3:0]    count0;
    logic [2:0]    trig_idx0;
    logic [DW-1:0] rd_pc0, rd_instr0, rd_addr0;

    int n_pass  = 0;
    int n_total = 0;
    logic [95:0] exp_q [$];

    always #5 clk = ~clk;

    cpu_trace_capture #(.DATA_W(DW), .DEPTH(8), .POST(2)) u_dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .pc(pc), .instruction(instruction),
        .address(address), .arm(arm), .trig_pc(trig_pc), .busy(busy), .done(done),
        .count(count), .trig_idx(trig_idx), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_addr(rd_addr)
    );

    cpu_trace_capture #(.DATA_W(DW), .DEPTH(8), .POST(0)) u_dut0 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .pc(pc), .instruction(instruction),
        .address(address), .arm(arm), .trig_pc(trig_pc), .busy(busy0), .done(done0),
        .count(count0), .trig_idx(trig_idx0), .rd_valid(rd_valid0), .rd_ready(rd_ready),
        .rd_pc(rd_pc0), .rd_instr(rd_instr0), .rd_addr(rd_addr0)
    );

    function automatic logic [95:0] entry(input logic [31:0] p);
        return {p, p ^ 32'hA5A5_0000, p + 32'h0000_1000};
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: every accepted readout entry is compared to the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL readout: got 0x%0h expected no entry", rd_pc);
            end else begin
                chk("readout", {rd_pc, rd_instr, rd_addr}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sample(input logic [31:0] p, input bit push);
        sample_en = 1'b1;
        {pc, instruction, address} = entry(p);
        if (push) begin
            exp_q.push_back(entry(p));
            while (exp_q.size() > 8) void'(exp_q.pop_front());
        end
        tick();
        sample_en = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        exp_q.delete();
        tick();
        arm = 1'b0;
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!rd_valid) break;
        end
        rd_ready = 1'b0;
        chk("drain_rd_valid", {95'd0, rd_valid}, 96'd0);
        chk("drain_left", 96'(exp_q.size()), 96'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", {95'd0, busy}, 96'd0);
        chk("rst_done", {95'd0, done}, 96'd0);
        chk("rst_rd_valid", {95'd0, rd_valid}, 96'd0);
        chk("rst_count", 96'(count), 96'd0);
        rst = 1'b0;
        tick();
        do_sample(32'h4, 1'b0);
        do_sample(32'h8, 1'b0);
        tick();
        chk("idle_count", 96'(count), 96'd0);

        // Basic capture
        trig_pc = 32'h8;
        do_arm();
        chk("arm_busy", {95'd0, busy}, 96'd1);
        do_sample(32'h0, 1'b1);
        do_sample(32'h4, 1'b1);
        do_sample(32'h8, 1'b1);
        chk("post0_done", {95'd0, done0}, 96'd1);
        chk("post0_trig_idx", 96'(trig_idx0), 96'd2);
        do_sample(32'hC, 1'b1);
        chk("basic_not_done", {95'd0, done}, 96'd0);
        do_sample(32'h10, 1'b1);
        chk("basic_done", {95'd0, done}, 96'd1);
        chk("basic_count", 96'(count), 96'd5);
        chk("basic_trig_idx", 96'(trig_idx), 96'd2);
        drain();

        // Wrap with backpressure
        trig_pc = 32'h24;
        do_arm();
        for (int i = 0; i < 12; i++) do_sample(32'(i * 4), 1'b1);
        chk("wrap_done", {95'd0, done}, 96'd1);
        chk("wrap_count", 96'(count), 96'd8);
        chk("wrap_trig_idx", 96'(trig_idx), 96'd5);
        for (int i = 0; i < 3; i++) begin
            chk("bp_rd_valid", {95'd0, rd_valid}, 96'd1);
            chk("bp_rd_pc", 96'(rd_pc), 96'h10);
            tick();
        end
        drain();

        // Mid-capture arm, then arm colliding with sample_en
        trig_pc = 32'h54;
        do_arm();
        do_sample(32'h40, 1'b0);
        do_sample(32'h44, 1'b0);
        do_sample(32'h48, 1'b0);
        do_arm();
        chk("rearm_count", 96'(count), 96'd0);
        chk("rearm_busy", {95'd0, busy}, 96'd1);
        arm = 1'b1;
        exp_q.delete();
        do_sample(32'h50, 1'b0);
        arm = 1'b0;
        chk("arm_sample_drop", 96'(count), 96'd0);
        do_sample(32'h54, 1'b1);
        do_sample(32'h58, 1'b1);
        do_sample(32'h5C, 1'b1);
        chk("rearm_done", {95'd0, done}, 96'd1);
        chk("rearm_count3", 96'(count), 96'd3);
        chk("rearm_trig_idx", 96'(trig_idx), 96'd0);
        drain();

        // Asynchronous reset while TRIGGERED
        trig_pc = 32'h60;
        do_arm();
        do_sample(32'h60, 1'b0);
        chk("trig_busy", {95'd0, busy}, 96'd1);
        rst = 1'b1;
        #1;
        chk("async_busy", {95'd0, busy}, 96'd0);
        chk("async_done0", {95'd0, done0}, 96'd0);
        chk("async_count", 96'(count), 96'd0);
        tick();
        rst = 1'b0;
        tick();

        // Duplicate samples
        trig_pc = 32'h100;
        do_arm();
        do_sample(32'h4, 1'b0);
        do_sample(32'h4, 1'b0);
        do_sample(32'h4, 1'b0);
        do_sample(32'h8, 1'b0);
`ifdef CPU_TRACE_DEDUP_EN
        chk("dedup_count", 96'(count), 96'd2);
`else
        chk("dedup_count", 96'(count), 96'd4);
`endif
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_trace_capture.md
# cpu_trace_capture

Synthesizable, parametrised trace buffer that records the CPU's `pc`, `instruction` and `address` on every qualified sample into a circular buffer. Capture stops a programmable number of samples after a PC-match trigger, and the trace is then read out oldest-first through a valid/ready port. It sits beside `cpu_logic` and provides in hardware what the simulation monitor prints, so traces can be taken on the board.

## Interface
Parameters:
- `DATA_W`, 32: width of pc, instruction and address.
- `DEPTH`, 16: buffer entries; must be a power of two, ≥ 4.
- `POST`, 4: samples stored after the trigger sample; 0 ≤ POST ≤ DEPTH-1.

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sample_en`  in  1: qualifies the current pc/instruction/address as one sample.
- `pc`  in  DATA_W: CPU program counter.
- `instruction`  in  DATA_W: current instruction word.
- `address`  in  DATA_W: current memory address.
- `arm`  in  1: one-cycle pulse that clears the buffer and starts a capture.
- `trig_pc`  in  DATA_W: trigger PC value; held stable while busy.
- `busy`  out  1: high in ARMED or TRIGGERED.
- `done`  out  1: high in DONE.
- `count`  out  clog2(DEPTH+1): valid entries; saturates at DEPTH.
- `trig_idx`  out  clog2(DEPTH): readout position of the trigger entry; valid while done.
- `rd_valid`  out  1: readout entry available.
- `rd_ready`  in  1: consumer accepts the entry.
- `rd_pc`, `rd_instr`, `rd_addr`  out  DATA_W each: readout entry.

## Operation
- States: IDLE, ARMED, TRIGGERED, DONE; reset enters IDLE.
- `arm` in any state:
  - next state ARMED
  - wr_ptr, count and post_left cleared; post_left is then loaded with POST
  - readout cursor cleared
  - `arm` has priority over a simultaneous `sample_en`, which is dropped.
- ARMED, sample stored:
  - write {pc, instruction, address} at wr_ptr
  - wr_ptr = (wr_ptr+1) mod DEPTH; count = min(count+1, DEPTH)
  - if pc == trig_pc: go to TRIGGERED, or straight to DONE when POST == 0.
- TRIGGERED, sample stored: write as above, decrement post_left; the sample that brings post_left to 0 moves the state to DONE. pc matches are ignored in this state.
- IDLE and DONE: samples are ignored.
- Entering DONE:
  - trig_idx = count − 1 − POST, using count after the final write
  - rd_ptr = (wr_ptr − count) mod DEPTH, the oldest entry
  - rd_left = count.
- DONE readout:
  - rd_valid = (rd_left ≠ 0)
  - rd_* show mem[rd_ptr] combinationally from the flop array
  - on rd_valid && rd_ready: rd_ptr++ mod DEPTH, rd_left−−
  - when rd_left reaches 0, rd_valid falls and the state stays DONE until `arm`
  - rd_valid is 0 in every state other than DONE.
- Because POST < DEPTH, the trigger entry is never overwritten. Older pre-trigger entries are overwritten silently on wrap.

## Timing
- All outputs reset to 0, state IDLE, buffer contents don't-care.
- A sample is written on the edge where sample_en is high. count reflects it the next cycle.
- done, trig_idx and rd_valid rise in the cycle after the edge that stored the final sample.
- Readout throughput is one entry per cycle. rd_* are stable while rd_valid && !rd_ready.
- `rst` asserted mid-capture or mid-readout forces IDLE immediately (asynchronous); busy, done and rd_valid drop without waiting for a clock.
- No combinational path exists from sample_en or pc to rd_*.

## Configuration
- `CPU_TRACE_DEDUP_EN` defined: a sample whose {pc, instruction, address} equals the most recently stored entry is not stored.
  - A dropped sample does not advance wr_ptr, count or post_left, and cannot fire the trigger.
  - The last-stored register is invalidated on `arm` and `rst`, so the first sample after arm is always stored.
- Not defined: every qualified sample is stored.

## Test plan
Parameters DEPTH=8, POST=2.
- Reset: assert `rst` for 2 cycles → busy=done=rd_valid=count=0, then IDLE. sample_en pulses in IDLE → count stays 0.
- Basic capture:
  - stimulus: trig_pc=0x8, arm, then samples pc=0x0,0x4,0x8,0xC,0x10
  - response: done=1 one cycle after the 0x10 sample; count=5; trig_idx=2; readout 0x0,0x4,0x8,0xC,0x10, then rd_valid=0.
- Wrap:
  - stimulus: trig_pc=0x24, samples pc=0x0…0x2C step 4 (12 samples)
  - response: count=8; trig_idx=5; readout 0x10,0x14,…,0x2C.
- Backpressure and POST=0:
  - with rd_ready low for 3 cycles, rd_pc stays 0x10 and rd_valid stays 1
  - with POST=0, done rises after the trigger sample and trig_idx=count−1.
- Mid-capture arm and reset:
  - arm after 3 samples → count=0, busy=1, readout contains only post-arm samples
  - `rst` mid-TRIGGERED → busy=0 within the same cycle
  - arm with sample_en in the same cycle → that sample is not stored.
- Dedup:
  - stimulus: samples pc=0x4 three times with identical instruction and address, then pc=0x8
  - response with CPU_TRACE_DEDUP_EN defined: count=2
  - response without it: count=4.
